// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Shares one signed multiplier among NUM_REQ requesters. A round-robin
// arbiter grants at most one operand pair per cycle. The pair is captured in
// an operand register (S1) that feeds the multiplier. An optional result
// register (S2) follows the multiplier. Products leave in grant order on a
// single valid/ready response port, tagged with the issuing requester's index.
//
// Configuration macro: MULT_ARB_OUT_REG_EN
//   defined   : S2 result register present, request-to-response latency 2,
//               up to 2 products in flight, multiplier output registered.
//   undefined : no S2, rsp_c is the multiplier output driven from S1,
//               latency 1, at most 1 product in flight.
//
// Parameters:
//   BITWIDTH  operand width (signed two's complement)
//   NUM_REQ   number of requesters (2..16)
//   ID_WIDTH  width of rsp_id, at least clog2(NUM_REQ)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand-pair valid
//   req_ready  per-requester grant, one-hot or zero (combinational)
//   req_a      packed operand A, requester i at [i*BITWIDTH +: BITWIDTH]
//   req_b      packed operand B, same packing
//   rsp_valid  product presented
//   rsp_ready  consumer accepts the presented product
//   rsp_c      signed full-precision product
//   rsp_id     index of the requester that issued the operands
//   busy       some pipeline stage holds a product
//   op_count   completed response handshakes, wraps at 16 bits
// -----------------------------------------------------------------------------

// Shared signed multiplier: full-precision product, cannot overflow.
module mult_arbiter_mult #(
  parameter int unsigned W = 8
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] c_o
);

  // Both operands are sign-extended to the product width before multiplying.
  assign c_o = (2*W)'(a_i) * (2*W)'(b_i);

endmodule

module mult_arbiter #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_a,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2*BITWIDTH-1:0]        rsp_c,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic                         busy,
  output logic [15:0]                  op_count
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                         active_q;
  logic                         s1_valid_q, s1_valid_d;
  logic [BITWIDTH-1:0]          s1_a_q, s1_a_d;
  logic [BITWIDTH-1:0]          s1_b_q, s1_b_d;
  logic [ID_WIDTH-1:0]          s1_id_q, s1_id_d;
  logic [ID_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
  logic [15:0]                  op_count_q, op_count_d;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic signed [2*BITWIDTH-1:0] mult_c;
  logic                         s1_free;
  logic [NUM_REQ-1:0]           valid_rot;
  logic [NUM_REQ-1:0]           oh_rot;
  logic [2*NUM_REQ-1:0]         oh_dbl;
  logic [NUM_REQ-1:0]           grant_oh;
  logic [ID_WIDTH-1:0]          grant_id;
  logic [BITWIDTH-1:0]          grant_a;
  logic [BITWIDTH-1:0]          grant_b;
  logic                         handshake;
  logic                         rsp_fire;

  // ---------------------------------------------------------------------------
  // Shared multiplier, always driven from the operand register
  // ---------------------------------------------------------------------------
  mult_arbiter_mult #(
    .W (BITWIDTH)
  ) u_mult (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .c_o (mult_c)
  );

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  //
  // The request vector is rotated right by rr_ptr so that the requester at the
  // pointer lands on bit 0; a fixed lowest-index priority pick on the rotated
  // vector then gives "first valid at or after rr_ptr". The one-hot pick is
  // rotated back by shifting left in a double-width vector and folding.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    oh_rot    = '0;
    // Descending scan: the last hit written is the lowest set index.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        oh_rot    = '0;
        oh_rot[k] = 1'b1;
      end
    end
    oh_dbl   = {{NUM_REQ{1'b0}}, oh_rot} << rr_ptr_q;
    grant_oh = oh_dbl[NUM_REQ-1:0] | oh_dbl[2*NUM_REQ-1:NUM_REQ];
  end

  // Index and operands of the granted requester. Only the granted lane's
  // operands reach the mux output; other lanes are never observed.
  always_comb begin
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_id = ID_WIDTH'(i);
        grant_a  = req_a[i*BITWIDTH +: BITWIDTH];
        grant_b  = req_b[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Grants are withheld while reset is asserted and in the first cycle after
  // release, via active_q, so req_ready is 0 during reset even with requests
  // pending.
  assign req_ready = (s1_free && active_q) ? grant_oh : '0;
  assign handshake = |req_ready;

  // ---------------------------------------------------------------------------
  // Output stage and S1 flow control
  // ---------------------------------------------------------------------------
`ifdef MULT_ARB_OUT_REG_EN

  logic                         s2_valid_q, s2_valid_d;
  logic [2*BITWIDTH-1:0]        s2_c_q, s2_c_d;
  logic [ID_WIDTH-1:0]          s2_id_q, s2_id_d;
  logic                         s2_free;

  assign s2_free = !s2_valid_q || rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // S2 follows S1 whenever it can accept. Data is only captured from a valid
  // S1 so the result register holds its last product while idle.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_c_d     = s2_c_q;
    s2_id_d    = s2_id_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_c_d  = mult_c;
        s2_id_d = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_id_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_c_q     <= s2_c_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_c     = s2_c_q;
  assign rsp_id    = s2_id_q;
  assign busy      = s1_valid_q || s2_valid_q;

`else

  // S1 is the output stage: it can take a new pair when empty or when its
  // current product is being accepted in this same cycle.
  assign s1_free = !s1_valid_q || rsp_ready;

  assign rsp_valid = s1_valid_q;
  assign rsp_c     = mult_c;
  assign rsp_id    = s1_id_q;
  assign busy      = s1_valid_q;

`endif

  assign rsp_fire = rsp_valid && rsp_ready;
  assign op_count = op_count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic: S1, round-robin pointer, completion counter
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    op_count_d = op_count_q;

    // When S1 can move, it either takes the granted pair or empties.
    if (s1_free) begin
      s1_valid_d = handshake;
    end

    if (handshake) begin
      s1_a_d   = grant_a;
      s1_b_d   = grant_b;
      s1_id_d  = grant_id;
      // Pointer moves just past the winner so it has lowest priority next.
      rr_ptr_d = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                      : grant_id + ID_WIDTH'(1);
    end

    if (rsp_fire) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the operand/id registers are reset along with the valid bits because
  // rsp_c and rsp_id must read 0 straight out of reset, not just rsp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      active_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      rr_ptr_q   <= rr_ptr_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Directed scenarios plus a randomized stream for mult_arbiter. A behavioural
// model keeps the in-flight products as a queue in grant order, each with its
// age in cycles; the expected grant, response, busy flag and completion count
// are derived from that queue every cycle. Works with and without
// MULT_ARB_OUT_REG_EN.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int BW  = 8;
  localparam int IDW = 2;
`ifdef MULT_ARB_OUT_REG_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*BW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*BW-1:0]   rsp_c;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [15:0]       op_count;

  mult_arbiter #(
    .BITWIDTH (BW),
    .NUM_REQ  (N),
    .ID_WIDTH (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] c;
    int          id;
    int          age;
  } item_t;

  typedef struct {
    logic [15:0] c;
    int          id;
  } obs_t;

  item_t q[$];        // products granted but not yet accepted, oldest first
  obs_t  obs[$];      // products the DUT handed over, for directed checks
  int    m_ptr   = 0;
  int    m_count = 0;
  int    m_grants = 0;

  function automatic int model_grant(input logic [N-1:0] vld, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (vld[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*BW-1:0] with_op(input logic [N*BW-1:0] base,
                                              input int idx, input int v);
    logic [N*BW-1:0] r;
    r = base;
    r[idx*BW +: BW] = BW'(v);
    return r;
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare outputs shortly
  // after, then advance the model across the rising edge.
  task automatic run_cycle(input logic [N-1:0] vld, input logic [N*BW-1:0] a,
                           input logic [N*BW-1:0] b, input logic rdy);
    int           g;
    bit           exp_rv;
    logic [N-1:0] exp_rdy;
    int           ai;
    int           bi;
    item_t        it;
    obs_t         o;

    @(negedge clk);
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;

    g = ((q.size() < CAP) || rdy) ? model_grant(vld, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = (q.size() > 0) && (q[0].age >= LAT - 1);

    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_c",  32'(rsp_c),  32'(q[0].c));
      check("rsp_id", 32'(rsp_id), 32'(q[0].id));
    end
    check("busy",     32'(busy),     32'(q.size() > 0));
    check("op_count", 32'(op_count), 32'(m_count));

    if (rsp_valid && rsp_ready) begin
      o.c  = rsp_c;
      o.id = int'(rsp_id);
      obs.push_back(o);
    end

    @(posedge clk);
    if (exp_rv && rdy) begin
      void'(q.pop_front());
      m_count = (m_count + 1) % 65536;
    end
    foreach (q[i]) q[i].age++;
    if (g >= 0) begin
      ai     = $signed(a[g*BW +: BW]);
      bi     = $signed(b[g*BW +: BW]);
      it.c   = 16'(ai * bi);
      it.id  = g;
      it.age = 0;
      q.push_back(it);
      m_ptr = (g + 1) % N;
      m_grants++;
    end
    #2;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) run_cycle('0, $urandom, $urandom, 1'b1);
  endtask

  // Asserts reset between clock edges, with requests pending, and checks that
  // every output is cleared at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_c",     32'(rsp_c),     32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_op_count",  32'(op_count),  32'h0);
    q.delete();
    m_ptr   = 0;
    m_count = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [N*BW-1:0] a;
    logic [N*BW-1:0] b;
    int              g0;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // All requesters valid from reset: grants 0,1,2,3,0,1,2,3.
    do_reset();
    obs.delete();
    for (int i = 0; i < 8; i++) run_cycle('1, $urandom, $urandom, 1'b1);
    drain(3);
    check("t2_n", 32'(obs.size()), 32'd8);
    for (int i = 0; i < obs.size(); i++) check("t2_id", 32'(obs[i].id), 32'(i % N));
    check("t2_op_count", 32'(op_count), 32'd8);

    // Reset with products in flight; restart grants from requester 0.
    obs.delete();
    for (int i = 0; i < 3; i++) run_cycle('1, $urandom, $urandom, 1'b0);
    check("t5_inflight", 32'(busy), 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle('1, $urandom, $urandom, 1'b1);
    drain(3);
    check("t5_n", 32'(obs.size()), 32'd4);
    if (obs.size() > 0) check("t5_first_id", 32'(obs[0].id), 32'd0);
    check("t5_op_count", 32'(op_count), 32'd4);

    // Only requester 2: 3 * -4.
    do_reset();
    obs.delete();
    a = with_op($urandom, 2, 3);
    b = with_op($urandom, 2, -4);
    run_cycle(4'b0100, a, b, 1'b1);
    drain(3);
    check("t1_n", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      check("t1_c",  32'(obs[0].c),  32'h0000_FFF4);
      check("t1_id", 32'(obs[0].id), 32'd2);
    end
    check("t1_op_count", 32'(op_count), 32'd1);

    // Extreme operands on requester 0.
    obs.delete();
    run_cycle(4'b0001, with_op($urandom, 0, -128), with_op($urandom, 0, -128), 1'b1);
    run_cycle(4'b0001, with_op($urandom, 0, -128), with_op($urandom, 0,  127), 1'b1);
    run_cycle(4'b0001, with_op($urandom, 0,  127), with_op($urandom, 0,  127), 1'b1);
    drain(3);
    check("t3_n", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      check("t3_c0", 32'(obs[0].c), 32'h0000_4000);
      check("t3_c1", 32'(obs[1].c), 32'h0000_C080);
      check("t3_c2", 32'(obs[2].c), 32'h0000_3F01);
    end

    // Only requesters 1 and 3 (pointer is at 1 after the last grant to 0).
    obs.delete();
    for (int i = 0; i < 4; i++) run_cycle(4'b1010, $urandom, $urandom, 1'b1);
    drain(3);
    check("t6_n", 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size(); i++) check("t6_id", 32'(obs[i].id), (i % 2 == 0) ? 32'd1 : 32'd3);

    // Backpressure for 5 cycles under continuous requests.
    obs.delete();
    m_grants = 0;
    for (int i = 0; i < 2; i++)  run_cycle('1, $urandom, $urandom, 1'b1);
    for (int i = 0; i < 5; i++)  run_cycle('1, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 8; i++)  run_cycle('1, $urandom, $urandom, 1'b1);
    drain(3);
    check("t4_n", 32'(obs.size()), 32'(m_grants));
    g0 = (obs.size() > 0) ? obs[0].id : 0;
    for (int i = 1; i < obs.size(); i++) check("t4_order", 32'(obs[i].id), 32'((g0 + i) % N));

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      run_cycle(N'($urandom), $urandom, $urandom, ($urandom % 4) != 0);
    end
    drain(3);
    check("rand_empty", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
